// File: rtl/xgmii_rx_framer.sv
// xgmii_rx_framer
//   Frame delimiter behind the XGMII RX lane aligner. Start is always in lane 0.
//   The preamble/SFD word is dropped. Data words are written to an RX FIFO tagged
//   with sop/eop/byte_en/err. The input cannot be stalled, so a full FIFO either
//   drops the whole frame (at Start) or truncates it with err (mid-frame).
//
//   Pipeline: stage 1 registers the input word plus its lane decode. Stage 2
//   decides using that word and the live input word, which is the next word in
//   the stream. The outputs are registered, so a word on xgmii_rxd at cycle N
//   produces its write at cycle N+2.
//
//   Optional feature: define RX_STATS_EN to enable the three 32-bit statistics
//   counters. When it is undefined, the counter ports are tied to zero.
//
// Ports
//   xgmii_rx_clk    clock
//   sys_rst_n       synchronous reset, active low
//   xgmii_rxd       [71:64] per-lane ctrl, lane i data = [8i+7:8i]
//   fifo_full       FIFO almost-full (>=2 free entries while asserted)
//   wr_en           FIFO write strobe; qualifies dout/byte_en/sop/eop/err
//   dout            frame data, lane 0 = first byte
//   byte_en         lane-valid mask, 8'hff except on a short EOP word
//   sop / eop       first / last data word of a frame
//   err             with eop only: bad frame (error char, overlong, overflow)
//   rx_frames       good frames written
//   rx_err_frames   frames closed with err
//   rx_drop_frames  frames dropped entirely at Start
module xgmii_rx_framer #(
  parameter int MAX_FRAME_WORDS = 190
) (
  input  logic        xgmii_rx_clk,
  input  logic        sys_rst_n,
  input  logic [71:0] xgmii_rxd,
  input  logic        fifo_full,
  output logic        wr_en,
  output logic [63:0] dout,
  output logic [7:0]  byte_en,
  output logic        sop,
  output logic        eop,
  output logic        err,
  output logic [31:0] rx_frames,
  output logic [31:0] rx_err_frames,
  output logic [31:0] rx_drop_frames
);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, DROP = 2'd2} state_t;

  localparam logic [15:0] LAST_IDX = 16'(MAX_FRAME_WORDS - 1);

  // Lane decode of the incoming word. A value of 8 in in_t means no terminate.
  logic [7:0]  in_ctrl;
  logic [63:0] in_data;
  logic [3:0]  in_t;
  logic        in_start, in_idle;

  assign in_ctrl = xgmii_rxd[71:64];
  assign in_data = xgmii_rxd[63:0];

  always_comb begin
    in_t = 4'd8;
    for (int i = 7; i >= 0; i--)
      if (in_ctrl[i] && in_data[8*i +: 8] == 8'hFD) in_t = 4'(i);
    in_start = in_ctrl[0] && in_data[7:0] == 8'hFB;
    in_idle  = in_ctrl == 8'hff && in_data[7:0] == 8'h07;
  end

  // Stage 1: the word under decision.
  logic        s1_vld_q, s1_start_q, s1_idle_q, s1_full_q;
  logic [7:0]  s1_ctrl_q;
  logic [63:0] s1_data_q;
  logic [3:0]  s1_t_q;

  // Stage 2 state and next-state signals.
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sop_pend_q, sop_pend_d;
  logic        wr_d, sop_d, eop_d, err_d;
  logic [63:0] dout_d;
  logic [7:0]  be_d;

  // These are the lanes below the terminate, or all lanes when there is none.
  // Any ctrl char in them cannot be FD, so it is an error char.
  logic [7:0] low_mask;
  logic       err_char, has_t;
  assign low_mask = ~(8'hff << s1_t_q);
  assign err_char = |(s1_ctrl_q & low_mask);
  assign has_t    = s1_t_q != 4'd8;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sop_pend_d = sop_pend_q;
    wr_d       = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    err_d      = 1'b0;
    dout_d     = 64'h0;
    be_d       = 8'h0;
    if (s1_vld_q) begin
      unique case (state_q)
        IDLE: if (s1_start_q) begin
          if (s1_full_q) state_d = DROP;
          else begin
            state_d    = DATA;
            cnt_d      = 16'd0;
            sop_pend_d = 1'b1;
          end
        end
        DATA: begin
          if (!err_char && s1_t_q == 4'd0) begin
            // A terminate in lane 0 here only follows an empty frame; there is nothing to write.
            state_d = IDLE;
          end else begin
            wr_d       = 1'b1;
            dout_d     = s1_data_q;
            be_d       = 8'hff;
            sop_d      = sop_pend_q;
            sop_pend_d = 1'b0;
            cnt_d      = (cnt_q == 16'hffff) ? cnt_q : cnt_q + 16'd1;
            if (err_char) begin
              eop_d = 1'b1; err_d = 1'b1; state_d = DROP;
            end else if (has_t) begin
              eop_d = 1'b1; be_d = low_mask; state_d = IDLE;
            end else if (in_t == 4'd0) begin
              // Lookahead: the next word holds only the terminate, so this word closes the frame.
              eop_d = 1'b1; state_d = IDLE;
            end else if (cnt_q >= LAST_IDX) begin
              eop_d = 1'b1; err_d = 1'b1; state_d = DROP;
            end else if (s1_full_q) begin
              // The FIFO still has a free slot for this closing word.
              eop_d = 1'b1; err_d = 1'b1; state_d = DROP;
            end
          end
        end
        DROP: if (has_t || s1_idle_q) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge xgmii_rx_clk) begin
    if (!sys_rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_start_q <= 1'b0;
      s1_idle_q  <= 1'b0;
      s1_full_q  <= 1'b0;
      s1_ctrl_q  <= 8'h0;
      s1_data_q  <= 64'h0;
      s1_t_q     <= 4'd8;
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      sop_pend_q <= 1'b0;
      wr_en      <= 1'b0;
      dout       <= 64'h0;
      byte_en    <= 8'h0;
      sop        <= 1'b0;
      eop        <= 1'b0;
      err        <= 1'b0;
    end else begin
      s1_vld_q   <= 1'b1;
      s1_start_q <= in_start;
      s1_idle_q  <= in_idle;
      s1_full_q  <= fifo_full;
      s1_ctrl_q  <= in_ctrl;
      s1_data_q  <= in_data;
      s1_t_q     <= in_t;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sop_pend_q <= sop_pend_d;
      wr_en      <= wr_d;
      dout       <= dout_d;
      byte_en    <= be_d;
      sop        <= sop_d;
      eop        <= eop_d;
      err        <= err_d;
    end
  end

`ifdef RX_STATS_EN
  logic [31:0] frames_q, err_frames_q, drop_frames_q;
  logic        drop_inc;
  assign drop_inc = s1_vld_q && state_q == IDLE && s1_start_q && s1_full_q;

  always_ff @(posedge xgmii_rx_clk) begin
    if (!sys_rst_n) begin
      frames_q      <= 32'h0;
      err_frames_q  <= 32'h0;
      drop_frames_q <= 32'h0;
    end else begin
      if (wr_d && eop_d && !err_d) frames_q     <= frames_q + 32'd1;
      if (wr_d && eop_d && err_d)  err_frames_q <= err_frames_q + 32'd1;
      if (drop_inc)                drop_frames_q <= drop_frames_q + 32'd1;
    end
  end

  assign rx_frames      = frames_q;
  assign rx_err_frames  = err_frames_q;
  assign rx_drop_frames = drop_frames_q;
`else
  assign rx_frames      = 32'h0;
  assign rx_err_frames  = 32'h0;
  assign rx_drop_frames = 32'h0;
`endif

endmodule

// File: tb/tb_xgmii_rx_framer.sv
// Directed bench for xgmii_rx_framer: a default instance, plus a second
// instance with MAX_FRAME_WORDS=4 that is held in reset until the overlong test.
module tb_xgmii_rx_framer;

`ifdef RX_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  localparam logic [71:0] IDLEW = {8'hff, {8{8'h07}}};
  localparam logic [71:0] TERM0 = {8'hff, {7{8'h07}}, 8'hFD};
  localparam logic [71:0] START = {8'h01, 8'hD5, {6{8'h55}}, 8'hFB};
  localparam logic [71:0] T4W   = {8'hf0, 8'h07, 8'h07, 8'h07, 8'hFD, 8'h44, 8'h33, 8'h22, 8'h11};
  localparam logic [71:0] BADW  = {8'h08, 32'hDA7A0003, 8'hFE, 24'h221100};

  logic        clk, rst_n, rst4_n, full;
  logic [71:0] rxd;

  logic        wr_en, sop, eop, err;
  logic [63:0] dout;
  logic [7:0]  byte_en;
  logic [31:0] rx_frames, rx_err_frames, rx_drop_frames;

  logic        wr4, sop4, eop4, err4;
  logic [63:0] dout4;
  logic [7:0]  be4;
  logic [31:0] fr4, efr4, dfr4;

  xgmii_rx_framer dut (
    .xgmii_rx_clk(clk), .sys_rst_n(rst_n), .xgmii_rxd(rxd), .fifo_full(full),
    .wr_en(wr_en), .dout(dout), .byte_en(byte_en), .sop(sop), .eop(eop), .err(err),
    .rx_frames(rx_frames), .rx_err_frames(rx_err_frames), .rx_drop_frames(rx_drop_frames));

  xgmii_rx_framer #(.MAX_FRAME_WORDS(4)) dut4 (
    .xgmii_rx_clk(clk), .sys_rst_n(rst4_n), .xgmii_rxd(rxd), .fifo_full(full),
    .wr_en(wr4), .dout(dout4), .byte_en(be4), .sop(sop4), .eop(eop4), .err(err4),
    .rx_frames(fr4), .rx_err_frames(efr4), .rx_drop_frames(dfr4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write logs, captured on the falling edge.
  int          n, n4;
  logic        l_sop [256], l_eop [256], l_err [256];
  logic [7:0]  l_be  [256];
  logic [63:0] l_d   [256];
  logic        l4_sop[256], l4_eop[256], l4_err[256];
  logic [7:0]  l4_be [256];

  initial begin n = 0; n4 = 0; end

  always @(negedge clk) begin
    if (wr_en && n < 256) begin
      l_sop[n] <= sop; l_eop[n] <= eop; l_err[n] <= err; l_be[n] <= byte_en; l_d[n] <= dout;
      n <= n + 1;
    end
    if (wr4 && n4 < 256) begin
      l4_sop[n4] <= sop4; l4_eop[n4] <= eop4; l4_err[n4] <= err4; l4_be[n4] <= be4;
      n4 <= n4 + 1;
    end
  end

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] dd(input int k);
    return {32'hDA7A0000 + 32'(k), 32'hC0DE0000 + 32'(k)};
  endfunction

  function automatic logic [71:0] dw(input int k);
    return {8'h00, dd(k)};
  endfunction

  task automatic step(input logic [71:0] w, input logic f);
    rxd = w; full = f;
    @(posedge clk); #1;
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) step(IDLEW, 1'b0);
  endtask

  // Checks one frame in a log: the write count, exactly one eop, sop on the first
  // write, and byte_en/err on the last write.
  task automatic chk_frame(input string tag, input bit sel, input int base, input int cnt,
                           input logic [7:0] be, input logic er);
    int got;
    int eops;
    int last;
    got  = sel ? n4 - base : n - base;
    eops = 0;
    last = base + cnt - 1;
    chk({tag, "_cnt"}, 64'(got), 64'(cnt));
    for (int i = 0; i < cnt; i++) eops += int'(sel ? l4_eop[base+i] : l_eop[base+i]);
    chk({tag, "_eops"}, 64'(eops), 64'd1);
    chk({tag, "_sop"},  64'(sel ? l4_sop[base] : l_sop[base]), 64'd1);
    chk({tag, "_eop"},  64'(sel ? l4_eop[last] : l_eop[last]), 64'd1);
    chk({tag, "_be"},   64'(sel ? l4_be[last]  : l_be[last]),  64'(be));
    chk({tag, "_err"},  64'(sel ? l4_err[last] : l_err[last]), 64'(er));
  endtask

  initial begin
    int base, base4;
    rst_n = 1'b0; rst4_n = 1'b0; rxd = IDLEW; full = 1'b0;
    step(IDLEW, 1'b0); step(IDLEW, 1'b0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_flags", 64'({sop, eop, err}), 64'd0);
    chk("rst_dout", dout, 64'd0);
    chk("rst_be", 64'(byte_en), 64'd0);
    chk("rst_frames", 64'(rx_frames), 64'd0);
    rst_n = 1'b1;
    step(IDLEW, 1'b0); step(IDLEW, 1'b0);

    // 1: eight data words, then a terminate in lane 0.
    base = n;
    step(START, 1'b0);
    step(dw(1), 1'b0);
    chk("t1_lat_nowr", 64'(wr_en), 64'd0);
    step(dw(2), 1'b0);
    chk("t1_lat_wr", 64'(wr_en), 64'd1);
    chk("t1_lat_sop", 64'(sop), 64'd1);
    chk("t1_lat_dout", dout, dd(1));
    for (int k = 3; k <= 8; k++) step(dw(k), 1'b0);
    step(TERM0, 1'b0);
    flush();
    chk_frame("t1", 1'b0, base, 8, 8'hff, 1'b0);
    chk("t1_last_dout", l_d[base+7], dd(8));
    chk("t1_frames", 64'(rx_frames), 64'(STATS));

    // 2: seven data words, then a terminate in lane 4.
    base = n;
    step(START, 1'b0);
    for (int k = 11; k <= 17; k++) step(dw(k), 1'b0);
    step(T4W, 1'b0);
    flush();
    chk_frame("t2", 1'b0, base, 8, 8'h0f, 1'b0);

    // 3: error char FE in lane 3 of the third word.
    base = n;
    step(START, 1'b0);
    step(dw(21), 1'b0); step(dw(22), 1'b0); step(BADW, 1'b0);
    step(dw(24), 1'b0); step(dw(25), 1'b0); step(TERM0, 1'b0);
    flush();
    chk_frame("t3", 1'b0, base, 3, 8'hff, 1'b1);
    chk("t3_err_frames", 64'(rx_err_frames), 64'(STATS));

    // 4: full at Start means the frame is dropped; the next frame goes through.
    base = n;
    step(START, 1'b1);
    for (int k = 31; k <= 33; k++) step(dw(k), 1'b0);
    step(TERM0, 1'b0);
    flush();
    chk("t4_drop_nwr", 64'(n - base), 64'd0);
    chk("t4_drop_cnt", 64'(rx_drop_frames), 64'(STATS));
    base = n;
    step(START, 1'b0); step(dw(41), 1'b0); step(dw(42), 1'b0); step(TERM0, 1'b0);
    flush();
    chk_frame("t4b", 1'b0, base, 2, 8'hff, 1'b0);
    // Mid-frame full truncates the frame at that word.
    base = n;
    step(START, 1'b0); step(dw(51), 1'b0); step(dw(52), 1'b1); step(dw(53), 1'b0);
    step(TERM0, 1'b0);
    flush();
    chk_frame("t4c", 1'b0, base, 2, 8'hff, 1'b1);
    // A single-word frame has sop and eop on the same write.
    base = n;
    step(START, 1'b0); step(dw(61), 1'b0); step(TERM0, 1'b0);
    flush();
    chk_frame("t4d", 1'b0, base, 1, 8'hff, 1'b0);
    chk("t4_err_frames", 64'(rx_err_frames), 64'(2 * STATS));

    // 5: a ten-word frame into MAX_FRAME_WORDS=4 is cut after four words.
    rst4_n = 1'b1;
    step(IDLEW, 1'b0);
    base = n; base4 = n4;
    step(START, 1'b0);
    for (int k = 71; k <= 80; k++) step(dw(k), 1'b0);
    step(TERM0, 1'b0);
    flush();
    chk_frame("t5", 1'b1, base4, 4, 8'hff, 1'b1);
    chk("t5_err_frames", 64'(efr4), 64'(STATS));
    chk_frame("t5_big", 1'b0, base, 10, 8'hff, 1'b0);

    // 6: a reset pulse mid-frame abandons the frame without an eop.
    base = n;
    step(START, 1'b0); step(dw(81), 1'b0); step(dw(82), 1'b0);
    rst_n = 1'b0;
    step(dw(83), 1'b0);
    chk("t6_rst_wr", 64'(wr_en), 64'd0);
    rst_n = 1'b1;
    step(dw(84), 1'b0); step(TERM0, 1'b0);
    flush();
    chk("t6_abandon_cnt", 64'(n - base), 64'd1);
    chk("t6_abandon_eop", 64'(l_eop[base]), 64'd0);
    chk("t6_frames_clr", 64'(rx_frames), 64'd0);
    base = n;
    step(START, 1'b0);
    step(dw(91), 1'b0);
    chk("t6_lat_nowr", 64'(wr_en), 64'd0);
    step(dw(92), 1'b0);
    chk("t6_lat_wr", 64'(wr_en), 64'd1);
    chk("t6_lat_dout", dout, dd(91));
    step(TERM0, 1'b0);
    flush();
    chk_frame("t6b", 1'b0, base, 2, 8'hff, 1'b0);
    chk("t6_frames", 64'(rx_frames), 64'(STATS));
    chk("t6_err_frames", 64'(rx_err_frames), 64'd0);
    chk("t6_drop_frames", 64'(rx_drop_frames), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
